uart_rx_deserializer: RTL

//  Serial-to-parallel UART receiver between the board rx pin and the controller's command buffer.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 33 +++
 rtl/uart_rx_deserializer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helper functions,
// common to the receiver and the matching transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_e;

    // Integer division: the residual baud error is absorbed by mid-bit sampling.
    function automatic int cycles_per_bit(input int clk_freq, input int bit_rate);
        return clk_freq / bit_rate;
    endfunction

    function automatic int half_bit_last(input int cpb);
        return cpb / 2 - 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value
// so idle-high lines come out of reset already idle.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronised rx, mid-bit sampling, LSB-first assembly into a
// one-entry valid/ready holding register. Optional UART_RX_MAJORITY_VOTE_EN adds 2-of-3 sample voting.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 25000000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx,
    output logic [PAYLOAD_BITS-1:0] data_o,
    output logic                    data_valid,
    input  logic                    data_ready,
    output logic                    framing_error,
    output logic                    overrun,
    output logic                    busy
);

    localparam int CPB   = cycles_per_bit(CLK_FREQ, BIT_RATE);
    localparam int HALF  = half_bit_last(CPB);
    localparam int CNT_W = $clog2(CPB);
    localparam int BIT_W = $clog2(PAYLOAD_BITS + 1);

    logic rx_s;
    logic sample;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Decisions move one cycle later so the window is mid-1, mid, mid+1.
    localparam int VOTE_LAG = 1;
    logic [1:0] hist_q, hist_d;

    always_comb hist_d = {hist_q[0], rx_s};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hist_q <= 2'b11;
        else        hist_q <= hist_d;
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    localparam int VOTE_LAG = 0;
    assign sample = rx_s;
`endif

    localparam logic [CNT_W-1:0] START_SAMPLE = CNT_W'(HALF + VOTE_LAG);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CPB - 1);
    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(PAYLOAD_BITS - 1);

    uart_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    framing_error_q, framing_error_d;
    logic                    overrun_q, overrun_d;
    logic                    stop_ok;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        stop_ok         = 1'b0;
        framing_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d   = ST_START;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt_q == START_SAMPLE) begin
                    cnt_d   = '0;
                    state_d = sample ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {sample, shift_q[PAYLOAD_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sample) begin
                        stop_ok = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        framing_error_d = 1'b1;
                        state_d         = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pending word may be replaced only if it is being consumed this very cycle.
    always_comb begin
        data_d       = data_q;
        data_valid_d = data_valid_q;
        overrun_d    = 1'b0;
        if (stop_ok) begin
            if (!data_valid_q || data_ready) begin
                data_d       = shift_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            data_q          <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            data_q          <= data_d;
            data_valid_q    <= data_valid_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
        end
    end

    assign data_o        = data_q;
    assign data_valid    = data_valid_q;
    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
